mmio_port_bridge: RTL and testbench
===================================

MMIO_PORT_BRIDGE -- requirements
Module: mmio_port_bridge

Interface
REQ-001 Parameter DATA_W, default 32, data bus width.
REQ-002 Parameter SEL_BIT, default 7, address bit that selects the IO space (1) over data memory (0).
REQ-003 Parameter NUM_BTN, default 2, number of push-button channels (1..8).
REQ-004 Parameter SW_W, default 16, switch bank width (1..DATA_W).
REQ-005 Parameter LED_W, default 12, LED register width (1..DATA_W).
REQ-006 Parameter SYNC_STAGES, default 2, synchroniser depth for button and switch inputs (>=2).
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 writeEN  in  1  CPU store strobe.
REQ-010 readEN  in  1  CPU load strobe; used only for read side effects.
REQ-011 addr  in  32  CPU byte address.
REQ-012 writeData  in  DATA_W  CPU store data.
REQ-013 readData  out  DATA_W  CPU load data, combinational.
REQ-014 memWrite  out  1  data-memory write enable.
REQ-015 memReadData  in  DATA_W  data-memory read data.
REQ-016 btn  in  NUM_BTN  raw asynchronous push buttons, active-high.
REQ-017 switch  in  SW_W  raw asynchronous switches.
REQ-018 led  out  LED_W  LED register.
REQ-019 disp  out  32  seven-segment display data register.
REQ-020 irq  out  1  level interrupt request.

Function
REQ-021 io_sel = addr[SEL_BIT]; memWrite = writeEN & ~io_sel; IO writes occur only when writeEN & io_sel.
REQ-022 When io_sel=0, readData = memReadData; when io_sel=1, readData = IO register selected by addr[4:2], zero-extended.
REQ-023 Register map (offset addr[4:2]): 0 STATUS (R, read-clear), 1 SNAP (R), 2 LED (R/W), 3 DISP (R/W), 4 CTRL (R/W), 5..7 unmapped.
REQ-024 Unmapped offsets read 0; writes to unmapped or read-only offsets are ignored with no side effect.
REQ-025 btn and switch each pass through SYNC_STAGES flip-flops before any use; a press edge is sync_btn[i]=1 with previous synchronised value 0.
REQ-026 STATUS[NUM_BTN-1:0]: sticky flag i set on press edge of btn[i]; upper bits read 0.
REQ-027 STATUS read-clear: on the clock edge where readEN & io_sel & offset=0, flags present in the returned value clear; readData shows pre-clear value.
REQ-028 Simultaneous press edge and read-clear on the same flag: flag remains 1 (set wins).
REQ-029 SNAP[SW_W-1:0] captures synchronised switch on the press edge of btn[0] when CTRL[0]=0; captures every cycle when CTRL[0]=1 (live mode).
REQ-030 CTRL[0] live mode; CTRL[8+NUM_BTN-1:8] per-button interrupt mask; other CTRL bits read 0 and are not stored.
REQ-031 irq = |(STATUS flags & mask), registered from flag state, asserted the cycle after the flag sets.
REQ-032 LED and DISP load writeData (truncated to width) on the edge of an IO write; led/disp outputs are the registers directly.
REQ-033 readEN with io_sel=0 or offset!=0 has no side effect; writeEN and readEN together at offset 0 clear flags and ignore the write.
REQ-034 Write-to-readback latency: a value written in cycle N is returned by reads in cycle N+1.

Reset
REQ-035 While reset=0: STATUS, SNAP, LED, DISP, CTRL, all synchroniser stages and irq are 0, asynchronously and independent of clk.
REQ-036 Reset deassertion with btn held high produces no press edge (synchroniser previous value already 0 is primed from reset; first edge after release counts only once).
REQ-037 Reset asserted mid-operation discards pending flags and edges; no irq pulse on release.

Verification
REQ-038 Store 0x00000ABC to io offset 2, load it -> led=0xABC from next cycle, readData=0x00000ABC; memWrite stays 0.
REQ-039 Store with addr[7]=0 -> memWrite=1, IO registers unchanged; load with addr[7]=0 -> readData=memReadData.
REQ-040 switch=0x1234, pulse btn[0] with CTRL=0 -> SNAP reads 0x00001234 after SYNC_STAGES+1 cycles; STATUS=0x1; second load of STATUS returns 0x0.
REQ-041 CTRL=0x101, press btn[0] -> irq=1 one cycle after flag; press btn[0] on same cycle as STATUS read-clear -> flag still 1, irq stays 1.
REQ-042 CTRL=0x1, toggle switch each cycle -> SNAP tracks switch delayed SYNC_STAGES+1 cycles; write to offset 1 or 6 -> no register change, reads of 5..7 return 0.
REQ-043 Set LED, DISP, flags, then assert reset between clock edges -> all outputs 0 immediately; hold btn high through release -> STATUS remains 0.

Source files
------------

// File: rtl/mmio_port_bridge.sv
// CPU-side MMIO bridge: steers loads/stores between data memory and a small IO
// block (button flags, switch snapshot, LED/display registers, interrupt control).
module mmio_port_bridge #(
    parameter int DATA_W      = 32,
    parameter int SEL_BIT     = 7,
    parameter int NUM_BTN     = 2,
    parameter int SW_W        = 16,
    parameter int LED_W       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              writeEN,
    input  logic              readEN,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              memWrite,
    input  logic [DATA_W-1:0] memReadData,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [SW_W-1:0]   switch,
    output logic [LED_W-1:0]  led,
    output logic [31:0]       disp,
    output logic              irq
);

    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_SNAP   = 3'd1;
    localparam logic [2:0] OFF_LED    = 3'd2;
    localparam logic [2:0] OFF_DISP   = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;

    logic [SYNC_STAGES-1:0][NUM_BTN-1:0] btn_sync_q;
    logic [SYNC_STAGES-1:0][SW_W-1:0]    sw_sync_q;
    logic [SYNC_STAGES-1:0]              fill_q;
    logic [NUM_BTN-1:0] btn_prev_q, arm_q, arm_d;
    logic [NUM_BTN-1:0] status_q, status_d, mask_q, mask_d;
    logic [SW_W-1:0]    snap_q, snap_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic [31:0]        disp_q, disp_d;
    logic               live_q, live_d, irq_q, irq_d;

    logic               io_sel, io_wr, rd_clr;
    logic [2:0]         offset;
    logic [NUM_BTN-1:0] btn_s, press;
    logic [SW_W-1:0]    sw_s;
    logic [DATA_W-1:0]  io_rd;
    logic [DATA_W+31:0] wd_ext, disp_ext;
    logic               unused_bits;

    assign io_sel   = addr[SEL_BIT];
    assign offset   = addr[4:2];
    assign io_wr    = writeEN & io_sel;
    assign rd_clr   = readEN & io_sel & (offset == OFF_STATUS);
    assign memWrite = writeEN & ~io_sel;

    assign btn_s = btn_sync_q[SYNC_STAGES-1];
    assign sw_s  = sw_sync_q[SYNC_STAGES-1];
    // A button only produces edges once it has been seen released after reset,
    // so a button held through reset release never registers a press.
    assign press = btn_s & ~btn_prev_q & arm_q;

    assign wd_ext      = {32'b0, writeData};
    assign disp_ext    = {{DATA_W{1'b0}}, disp_q};
    assign unused_bits = ^{addr, wd_ext, disp_ext};

    always_comb begin
        io_rd = '0;
        case (offset)
            OFF_STATUS: io_rd[NUM_BTN-1:0] = status_q;
            OFF_SNAP:   io_rd[SW_W-1:0]    = snap_q;
            OFF_LED:    io_rd[LED_W-1:0]   = led_q;
            OFF_DISP:   io_rd              = disp_ext[DATA_W-1:0];
            OFF_CTRL: begin
                io_rd[0]            = live_q;
                io_rd[8 +: NUM_BTN] = mask_q;
            end
            default:    io_rd = '0;
        endcase
    end

    assign readData = io_sel ? io_rd : memReadData;

    always_comb begin
        // Set beats clear when a press lands on the read-clear edge.
        status_d = (status_q & ~{NUM_BTN{rd_clr}}) | press;
        snap_d   = (live_q | press[0]) ? sw_s : snap_q;
        arm_d    = arm_q | ({NUM_BTN{fill_q[SYNC_STAGES-1]}} & ~btn_s);
        irq_d    = |(status_q & mask_q);
        led_d    = led_q;
        disp_d   = disp_q;
        live_d   = live_q;
        mask_d   = mask_q;
        if (io_wr) begin
            case (offset)
                OFF_LED:  led_d = writeData[LED_W-1:0];
                OFF_DISP: disp_d = wd_ext[31:0];
                OFF_CTRL: begin
                    live_d = writeData[0];
                    mask_d = writeData[8 +: NUM_BTN];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_sync_q <= '0;
            sw_sync_q  <= '0;
            fill_q     <= '0;
            btn_prev_q <= '0;
            arm_q      <= '0;
            status_q   <= '0;
            snap_q     <= '0;
            led_q      <= '0;
            disp_q     <= '0;
            live_q     <= 1'b0;
            mask_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], btn};
            sw_sync_q  <= {sw_sync_q[SYNC_STAGES-2:0], switch};
            fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            btn_prev_q <= btn_s;
            arm_q      <= arm_d;
            status_q   <= status_d;
            snap_q     <= snap_d;
            led_q      <= led_d;
            disp_q     <= disp_d;
            live_q     <= live_d;
            mask_q     <= mask_d;
            irq_q      <= irq_d;
        end
    end

    assign led  = led_q;
    assign disp = disp_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_mmio_port_bridge.sv
// Directed bench for mmio_port_bridge: register-access vector table followed by
// hand-timed sequences for button edges, read-clear, live snapshot and reset.
module tb_mmio_port_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        writeEN, readEN;
    logic [31:0] addr, writeData, readData, memReadData;
    logic        memWrite;
    logic [1:0]  btn;
    logic [15:0] switch;
    logic [11:0] led;
    logic [31:0] disp;
    logic        irq;

    int n_vec = 0;
    int n_bad = 0;

    mmio_port_bridge dut (
        .clk(clk), .reset(reset), .writeEN(writeEN), .readEN(readEN),
        .addr(addr), .writeData(writeData), .readData(readData),
        .memWrite(memWrite), .memReadData(memReadData), .btn(btn),
        .switch(switch), .led(led), .disp(disp), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] mrd;
        logic [31:0] exp_rd;
        logic        exp_mw;
        logic [11:0] exp_led;
        logic [31:0] exp_disp;
    } vec_t;

    vec_t tv[19];

    function automatic vec_t mk(logic we, logic re, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] mrd, logic [31:0] exp_rd, logic exp_mw,
                                logic [11:0] exp_led, logic [31:0] exp_disp);
        vec_t v;
        v.we = we; v.re = re; v.a = a; v.wd = wd; v.mrd = mrd;
        v.exp_rd = exp_rd; v.exp_mw = exp_mw; v.exp_led = exp_led; v.exp_disp = exp_disp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic rd_at(input logic [31:0] a, input string name, input logic [31:0] exp);
        addr = a;
        #1;
        chk(name, readData, exp);
    endtask

    task automatic io_write(input logic [31:0] a, input logic [31:0] d);
        writeEN = 1'b1; addr = a; writeData = d;
        cyc();
        writeEN = 1'b0; writeData = '0;
    endtask

    logic [15:0] vals[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; writeEN = 1'b0; readEN = 1'b0; addr = '0; writeData = '0;
        memReadData = '0; btn = '0; switch = '0;

        tv[0]  = mk(1, 0, 32'h88,  32'h0000_0ABC, 32'h0, 32'h0,         0, 12'hABC, 32'h0);
        tv[1]  = mk(0, 1, 32'h88,  32'h0,         32'h0, 32'h0000_0ABC, 0, 12'hABC, 32'h0);
        tv[2]  = mk(1, 0, 32'h8C,  32'hDEAD_BEEF, 32'h0, 32'h0,         0, 12'hABC, 32'hDEAD_BEEF);
        tv[3]  = mk(0, 1, 32'h8C,  32'h0,         32'h0, 32'hDEAD_BEEF, 0, 12'hABC, 32'hDEAD_BEEF);
        tv[4]  = mk(1, 0, 32'h08,  32'h55, 32'h1234_5678, 32'h1234_5678, 1, 12'hABC, 32'hDEAD_BEEF);
        tv[5]  = mk(0, 1, 32'h0C,  32'h0,  32'hCAFE_F00D, 32'hCAFE_F00D, 0, 12'hABC, 32'hDEAD_BEEF);
        tv[6]  = mk(1, 0, 32'h84,  32'hFFFF,      32'h0, 32'h0,         0, 12'hABC, 32'hDEAD_BEEF);
        tv[7]  = mk(1, 0, 32'h98,  32'hFFFF,      32'h0, 32'h0,         0, 12'hABC, 32'hDEAD_BEEF);
        tv[8]  = mk(0, 1, 32'h94,  32'h0,         32'h0, 32'h0,         0, 12'hABC, 32'hDEAD_BEEF);
        tv[9]  = mk(0, 1, 32'h9C,  32'h0,         32'h0, 32'h0,         0, 12'hABC, 32'hDEAD_BEEF);
        tv[10] = mk(0, 1, 32'h84,  32'h0,         32'h0, 32'h0,         0, 12'hABC, 32'hDEAD_BEEF);
        tv[11] = mk(1, 0, 32'h88,  32'hFFFF_F123, 32'h0, 32'h0000_0ABC, 0, 12'h123, 32'hDEAD_BEEF);
        tv[12] = mk(0, 1, 32'h88,  32'h0,         32'h0, 32'h0000_0123, 0, 12'h123, 32'hDEAD_BEEF);
        tv[13] = mk(1, 0, 32'h90,  32'hFFFF_FFFE, 32'h0, 32'h0,         0, 12'h123, 32'hDEAD_BEEF);
        tv[14] = mk(0, 1, 32'h90,  32'h0,         32'h0, 32'h0000_0300, 0, 12'h123, 32'hDEAD_BEEF);
        tv[15] = mk(1, 0, 32'h90,  32'h0,         32'h0, 32'h0000_0300, 0, 12'h123, 32'hDEAD_BEEF);
        tv[16] = mk(0, 1, 32'h90,  32'h0,         32'h0, 32'h0,         0, 12'h123, 32'hDEAD_BEEF);
        tv[17] = mk(1, 1, 32'h80,  32'hFF,        32'h0, 32'h0,         0, 12'h123, 32'hDEAD_BEEF);
        tv[18] = mk(1, 0, 32'h10C, 32'h0,  32'h0BAD_F00D, 32'h0BAD_F00D, 1, 12'h123, 32'hDEAD_BEEF);

        vals = '{16'h0001, 16'hFFFE, 16'h1234, 16'h8000, 16'h00FF,
                 16'h5A5A, 16'hA5A5, 16'h0F0F, 16'hF0F0, 16'h7E81};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_led", {20'h0, led}, 32'h0);
        chk("rst_disp", disp, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_memwrite", {31'h0, memWrite}, 32'h0);
        rd_at(32'h80, "rst_status", 32'h0);
        rd_at(32'h84, "rst_snap", 32'h0);
        rd_at(32'h90, "rst_ctrl", 32'h0);
        reset = 1'b1;
        cyc(4);

        // Register access table
        for (int i = 0; i < 19; i++) begin
            writeEN = tv[i].we; readEN = tv[i].re; addr = tv[i].a;
            writeData = tv[i].wd; memReadData = tv[i].mrd;
            #1;
            chk($sformatf("tv%0d_rdata", i), readData, tv[i].exp_rd);
            chk($sformatf("tv%0d_memwrite", i), {31'h0, memWrite}, {31'h0, tv[i].exp_mw});
            cyc();
            chk($sformatf("tv%0d_led", i), {20'h0, led}, {20'h0, tv[i].exp_led});
            chk($sformatf("tv%0d_disp", i), disp, tv[i].exp_disp);
            chk($sformatf("tv%0d_irq", i), {31'h0, irq}, 32'h0);
        end
        writeEN = 1'b0; readEN = 1'b0; writeData = '0; memReadData = '0;

        // Snapshot on btn[0] press, then STATUS read-clear
        switch = 16'h1234;
        cyc(3);
        btn = 2'b01;
        cyc(2);
        rd_at(32'h84, "snap_not_early", 32'h0);
        cyc();
        rd_at(32'h84, "snap_captured", 32'h0000_1234);
        rd_at(32'h80, "status_set", 32'h1);
        chk("irq_masked", {31'h0, irq}, 32'h0);
        readEN = 1'b1;
        rd_at(32'h80, "status_first_load", 32'h1);
        cyc();
        rd_at(32'h80, "status_second_load", 32'h0);
        cyc();
        readEN = 1'b0;
        btn = 2'b00;
        cyc(4);

        // Interrupt timing and set-wins-over-clear
        io_write(32'h90, 32'h101);
        btn = 2'b01;
        cyc(3);
        rd_at(32'h80, "irq_flag_set", 32'h1);
        chk("irq_not_yet", {31'h0, irq}, 32'h0);
        cyc();
        chk("irq_asserted", {31'h0, irq}, 32'h1);
        btn = 2'b00;
        cyc(4);
        btn = 2'b01;
        cyc(2);
        readEN = 1'b1;
        rd_at(32'h80, "clr_vs_set_pre", 32'h1);
        cyc();
        readEN = 1'b0;
        rd_at(32'h80, "clr_vs_set_flag", 32'h1);
        chk("clr_vs_set_irq", {31'h0, irq}, 32'h1);
        btn = 2'b11;
        cyc(3);
        rd_at(32'h80, "status_both", 32'h3);
        readEN = 1'b1;
        cyc();
        readEN = 1'b0;
        rd_at(32'h80, "status_cleared", 32'h0);
        chk("irq_lags_clear", {31'h0, irq}, 32'h1);
        cyc();
        chk("irq_dropped", {31'h0, irq}, 32'h0);
        btn = 2'b00;
        cyc(4);
        btn = 2'b10;
        cyc(4);
        rd_at(32'h80, "btn1_flag", 32'h2);
        chk("btn1_masked_irq", {31'h0, irq}, 32'h0);
        readEN = 1'b1;
        cyc();
        readEN = 1'b0;
        btn = 2'b00;
        cyc(4);

        // Live snapshot mode
        io_write(32'h90, 32'h1);
        addr = 32'h84;
        for (int i = 0; i < 10; i++) begin
            switch = vals[i];
            cyc();
            if (i >= 2) rd_at(32'h84, $sformatf("live_snap%0d", i), {16'h0, vals[i-2]});
        end
        cyc(2);
        io_write(32'h90, 32'h0);
        switch = 16'h0000;
        cyc(4);
        rd_at(32'h84, "snap_frozen", {16'h0, vals[9]});
        io_write(32'h84, 32'hFFFF);
        rd_at(32'h84, "snap_ro", {16'h0, vals[9]});

        // Asynchronous reset mid-operation, button held through release
        io_write(32'h88, 32'h5A5);
        io_write(32'h8C, 32'h1357_2468);
        io_write(32'h90, 32'h300);
        btn = 2'b10;
        cyc(4);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        chk("pre_rst_led", {20'h0, led}, 32'h5A5);
        rd_at(32'h80, "pre_rst_status", 32'h2);
        @(posedge clk);
        #3;
        reset = 1'b0;
        btn = 2'b11;
        #1;
        chk("async_rst_led", {20'h0, led}, 32'h0);
        chk("async_rst_disp", disp, 32'h0);
        chk("async_rst_irq", {31'h0, irq}, 32'h0);
        rd_at(32'h80, "async_rst_status", 32'h0);
        @(negedge clk);
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            rd_at(32'h80, $sformatf("held_btn_status%0d", i), 32'h0);
            chk($sformatf("held_btn_irq%0d", i), {31'h0, irq}, 32'h0);
        end
        btn = 2'b00;
        cyc(4);
        io_write(32'h90, 32'h100);
        btn = 2'b01;
        cyc(3);
        rd_at(32'h80, "post_rst_press", 32'h1);
        cyc();
        chk("post_rst_irq", {31'h0, irq}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
